sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 28 ++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner encoding and bus widths.
// Optional conflict counter in the top is enabled by BUS_CONFLICT_CNT_EN.
package sram_arbiter_pkg;

  localparam int RAM_AW = 20;
  localparam int RAM_DW = 32;
  localparam int RAM_BW = 4;

  typedef logic              bit_t;
  typedef logic [RAM_AW-1:0] ram_addr_t;
  typedef logic [RAM_DW-1:0] word_t;
  typedef logic [RAM_BW-1:0] be_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port (fetch/data) arbiter onto a single asynchronous SRAM with registered strobes.
// Define BUS_CONFLICT_CNT_EN to add o_conflict_cnt (cycles with both requesters stalled).
//
// state       | meaning
// ST_IDLE     | no access; grant mem over fetch
// ST_RD       | read strobes active, data latched at end of cycle
// ST_WR_SETUP | address/data/ce driven, we_n high
// ST_WR_PULSE | we_n low for one cycle
// ST_WR_HOLD  | we_n high, data still driven
// ST_DONE     | strobes idle; owner's stall released for this cycle
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic [RAM_DW-1:0] o_if_rdata,
  output logic              o_if_stall_req,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [31:0]       i_mem_addr,
  input  logic [RAM_DW-1:0] i_mem_wdata,
  input  logic [RAM_BW-1:0] i_mem_be,
  output logic [RAM_DW-1:0] o_mem_rdata,
  output logic              o_mem_stall_req,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [RAM_DW-1:0] o_ram_data_o,
  input  logic [RAM_DW-1:0] i_ram_data_i,
  output logic              o_ram_data_oe,
  output logic [RAM_BW-1:0] o_ram_be_n,
  output logic              o_ram_ce_n,
  output logic              o_ram_oe_n,
  output logic              o_ram_we_n
`ifdef BUS_CONFLICT_CNT_EN
  ,
  output logic [31:0]       o_conflict_cnt
`endif
);

  state_t    r_state;
  owner_t    r_owner;
  ram_addr_t r_ram_addr;
  word_t     r_ram_data_o;
  bit_t      r_ram_data_oe;
  be_t       r_ram_be_n;
  bit_t      r_ram_ce_n;
  bit_t      r_ram_oe_n;
  bit_t      r_ram_we_n;
  word_t     r_if_rdata;
  word_t     r_mem_rdata;

  logic w_if_done;
  logic w_mem_done;
  logic w_unused;

  // Only word address bits [21:2] reach the SRAM.
  assign w_unused = ^{i_if_addr[31:22], i_if_addr[1:0], i_mem_addr[31:22], i_mem_addr[1:0]};

  assign w_if_done       = (r_state == ST_DONE) && (r_owner == OWN_IF);
  assign w_mem_done      = (r_state == ST_DONE) && (r_owner == OWN_MEM);
  assign o_if_stall_req  = i_if_req & ~w_if_done;
  assign o_mem_stall_req = i_mem_req & ~w_mem_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_IF;
      r_ram_addr    <= '0;
      r_ram_data_o  <= '0;
      r_ram_data_oe <= 1'b0;
      r_ram_be_n    <= '1;
      r_ram_ce_n    <= 1'b1;
      r_ram_oe_n    <= 1'b1;
      r_ram_we_n    <= 1'b1;
      r_if_rdata    <= '0;
      r_mem_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_req) begin
            r_owner    <= OWN_MEM;
            r_ram_addr <= i_mem_addr[21:2];
            r_ram_ce_n <= 1'b0;
            if (i_mem_we) begin
              r_ram_data_o  <= i_mem_wdata;
              r_ram_data_oe <= 1'b1;
              r_ram_be_n    <= ~i_mem_be;
              r_state       <= ST_WR_SETUP;
            end else begin
              r_ram_oe_n <= 1'b0;
              r_ram_be_n <= '0;
              r_state    <= ST_RD;
            end
          end else if (i_if_req) begin
            r_owner    <= OWN_IF;
            r_ram_addr <= i_if_addr[21:2];
            r_ram_ce_n <= 1'b0;
            r_ram_oe_n <= 1'b0;
            r_ram_be_n <= '0;
            r_state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (r_owner == OWN_IF) r_if_rdata  <= i_ram_data_i;
          else                   r_mem_rdata <= i_ram_data_i;
          r_ram_ce_n <= 1'b1;
          r_ram_oe_n <= 1'b1;
          r_ram_be_n <= '1;
          r_state    <= ST_DONE;
        end
        ST_WR_SETUP: begin
          r_ram_we_n <= 1'b0;
          r_state    <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          r_ram_we_n <= 1'b1;
          r_state    <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          r_ram_ce_n    <= 1'b1;
          r_ram_be_n    <= '1;
          r_ram_data_oe <= 1'b0;
          r_state       <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ram_addr    = r_ram_addr;
  assign o_ram_data_o  = r_ram_data_o;
  assign o_ram_data_oe = r_ram_data_oe;
  assign o_ram_be_n    = r_ram_be_n;
  assign o_ram_ce_n    = r_ram_ce_n;
  assign o_ram_oe_n    = r_ram_oe_n;
  assign o_ram_we_n    = r_ram_we_n;
  assign o_if_rdata    = r_if_rdata;
  assign o_mem_rdata   = r_mem_rdata;

`ifdef BUS_CONFLICT_CNT_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_conflict_cnt <= '0;
    else if (o_if_stall_req && o_mem_stall_req) r_conflict_cnt <= r_conflict_cnt + 32'd1;
  end

  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule
